spi_cfg_sync: RTL and testbench

Configuration synchroniser from the AXI register domain into the SPI clock domain. It is the mirror of the SPI status synchroniser. Each AXI-side config field passes through a multi-flop synchroniser with a stability counter, and is captured into a held output register only when stable. A lock FSM freezes the held config while the SPI subsystem runs and flags any attempt to change config during a run.

---
 rtl/spi_cfg_sync.sv | 139 +++++++++++++
 tb/tb_spi_cfg_sync.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_sync.sv
// spi_cfg_sync: carries AXI-side config words into the SPI clock domain, holds each one once it
// has settled, and freezes the held copy while the SPI subsystem is enabled.
module spi_cfg_sync_field #(
  parameter int W            = 1,
  parameter int DEPTH        = 3,
  parameter int STABLE_COUNT = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] din,
  output logic [W-1:0] synced,
  output logic         stable
);
  localparam int CW = $clog2(STABLE_COUNT + 1);
  logic [W-1:0]  s_q [DEPTH];
  logic [W-1:0]  s_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  assign synced = s_q[DEPTH-1];
  assign stable = (cnt_q == CW'(STABLE_COUNT));
  // The whole word must match across the last two stages, so multi-bit skew never leaks out.
  always_comb begin
    s_d[0] = din;
    for (int i = 1; i < DEPTH; i++) s_d[i] = s_q[i-1];
    cnt_d = (s_q[DEPTH-1] != s_q[DEPTH-2]) ? '0 : stable ? cnt_q : cnt_q + CW'(1);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_q   <= '{default: '0};
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module spi_cfg_sync #(
  parameter int DEPTH        = 3,
  parameter int STABLE_COUNT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        spi_en,
  input  logic [14:0] integ_thresh_avg,
  input  logic [31:0] integ_window,
  input  logic        integ_en,
  input  logic [15:0] boot_test_skip,
  input  logic        debug,
  output logic        spi_en_stable,
  output logic [14:0] integ_thresh_avg_stable,
  output logic [31:0] integ_window_stable,
  output logic        integ_en_stable,
  output logic [15:0] boot_test_skip_stable,
  output logic        debug_stable,
  output logic        cfg_locked,
  output logic        cfg_lock_viol,
  output logic        cfg_ready
);
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;
  state_e      state_q, state_d;
  logic        spi_en_q, spi_en_d, integ_en_q, integ_en_d, debug_q, debug_d;
  logic [14:0] thresh_q, thresh_d;
  logic [31:0] window_q, window_d;
  logic [15:0] skip_q, skip_d;
  logic        viol_q, viol_d, ready_q, ready_d;
  logic        syn_en, syn_ien, syn_dbg, st_en, st_thr, st_win, st_ien, st_skip, st_dbg;
  logic [14:0] syn_thr;
  logic [31:0] syn_win;
  logic [15:0] syn_skip;
  logic        upd, unlock, chg, all_st, all_eq;

  spi_cfg_sync_field #(.W(1), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_en (
    .clk(clk), .resetn(resetn), .din(spi_en), .synced(syn_en), .stable(st_en));
  spi_cfg_sync_field #(.W(15), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_thr (
    .clk(clk), .resetn(resetn), .din(integ_thresh_avg), .synced(syn_thr), .stable(st_thr));
  spi_cfg_sync_field #(.W(32), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_win (
    .clk(clk), .resetn(resetn), .din(integ_window), .synced(syn_win), .stable(st_win));
  spi_cfg_sync_field #(.W(1), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_ien (
    .clk(clk), .resetn(resetn), .din(integ_en), .synced(syn_ien), .stable(st_ien));
  spi_cfg_sync_field #(.W(16), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_skip (
    .clk(clk), .resetn(resetn), .din(boot_test_skip), .synced(syn_skip), .stable(st_skip));
  spi_cfg_sync_field #(.W(1), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_dbg (
    .clk(clk), .resetn(resetn), .din(debug), .synced(syn_dbg), .stable(st_dbg));

  always_comb begin
    upd    = (state_q == UNLOCKED);
    unlock = st_en && !syn_en;
    chg    = (st_thr && syn_thr != thresh_q) || (st_win && syn_win != window_q) ||
             (st_ien && syn_ien != integ_en_q) || (st_skip && syn_skip != skip_q) ||
             (st_dbg && syn_dbg != debug_q);
    all_st = st_en && st_thr && st_win && st_ien && st_skip && st_dbg;
    all_eq = syn_en == spi_en_q && syn_thr == thresh_q && syn_win == window_q &&
             syn_ien == integ_en_q && syn_skip == skip_q && syn_dbg == debug_q;
    spi_en_d   = st_en ? syn_en : spi_en_q;
    thresh_d   = (upd && st_thr) ? syn_thr : thresh_q;
    window_d   = (upd && st_win) ? syn_win : window_q;
    integ_en_d = (upd && st_ien) ? syn_ien : integ_en_q;
    skip_d     = (upd && st_skip) ? syn_skip : skip_q;
    debug_d    = (upd && st_dbg) ? syn_dbg : debug_q;
    state_d    = upd ? ((st_en && syn_en) ? LOCKED : UNLOCKED) : (unlock ? UNLOCKED : LOCKED);
    // Unlock wins over a same-edge change so the flag always starts clean for the next run.
    viol_d     = upd ? viol_q : (unlock ? 1'b0 : (viol_q || chg));
    ready_d    = upd && all_st && all_eq;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= UNLOCKED;
      spi_en_q   <= 1'b0;
      thresh_q   <= '0;
      window_q   <= '0;
      integ_en_q <= 1'b0;
      skip_q     <= '0;
      debug_q    <= 1'b0;
      viol_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      spi_en_q   <= spi_en_d;
      thresh_q   <= thresh_d;
      window_q   <= window_d;
      integ_en_q <= integ_en_d;
      skip_q     <= skip_d;
      debug_q    <= debug_d;
      viol_q     <= viol_d;
      ready_q    <= ready_d;
    end
  end

  assign spi_en_stable           = spi_en_q;
  assign integ_thresh_avg_stable = thresh_q;
  assign integ_window_stable     = window_q;
  assign integ_en_stable         = integ_en_q;
  assign boot_test_skip_stable   = skip_q;
  assign debug_stable            = debug_q;
  assign cfg_locked              = (state_q == LOCKED);
  assign cfg_lock_viol           = viol_q;
  assign cfg_ready               = ready_q;
endmodule

// File: tb/tb_spi_cfg_sync.sv
// tb_spi_cfg_sync: directed plus random stimulus checked against a window-based model of the
// settle/hold/lock rules.
module tb_spi_cfg_sync;
  localparam int DEPTH = 3;
  localparam int SC    = 2;
  logic        clk, resetn, spi_en, integ_en, debug;
  logic [14:0] thr;
  logic [31:0] win;
  logic [15:0] skip;
  logic        spi_en_stable, integ_en_stable, debug_stable, cfg_locked, cfg_lock_viol, cfg_ready;
  logic [14:0] thr_stable;
  logic [31:0] win_stable;
  logic [15:0] skip_stable;
  int nchk = 0, nfail = 0;

  spi_cfg_sync #(.DEPTH(DEPTH), .STABLE_COUNT(SC)) dut (
    .clk(clk), .resetn(resetn), .spi_en(spi_en), .integ_thresh_avg(thr), .integ_window(win),
    .integ_en(integ_en), .boot_test_skip(skip), .debug(debug),
    .spi_en_stable(spi_en_stable), .integ_thresh_avg_stable(thr_stable),
    .integ_window_stable(win_stable), .integ_en_stable(integ_en_stable),
    .boot_test_skip_stable(skip_stable), .debug_stable(debug_stable),
    .cfg_locked(cfg_locked), .cfg_lock_viol(cfg_lock_viol), .cfg_ready(cfg_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: inputs seen at each edge since reset; a field is settled once its synced value has
  // been identical for STABLE_COUNT+1 consecutive samples.
  logic [31:0] hist [6][4096];
  logic [31:0] m_held [6];
  bit          m_locked, m_viol, m_ready;
  int          n;
  localparam logic [31:0] MASK [6] = '{32'h1, 32'h7FFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF, 32'h1};

  function automatic logic [31:0] cur(int f);
    return f == 0 ? 32'(spi_en) : f == 1 ? 32'(thr) : f == 2 ? win :
           f == 3 ? 32'(integ_en) : f == 4 ? 32'(skip) : 32'(debug);
  endfunction

  function automatic logic [31:0] h(int f, int k);
    return (k < 1) ? 32'h0 : hist[f][k];
  endfunction

  function automatic bit settled(int f, int m);
    if (m < SC) return 1'b0;
    for (int k = m - DEPTH + 1 - SC; k <= m - DEPTH + 1; k++)
      if (h(f, k) !== h(f, m - DEPTH + 1)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    n = 0;
    for (int f = 0; f < 6; f++) m_held[f] = '0;
    m_locked = 0; m_viol = 0; m_ready = 0;
  endtask

  task automatic model_edge();
    bit st [6];
    logic [31:0] sy [6];
    bit all_st = 1, all_eq = 1;
    n++;
    for (int f = 0; f < 6; f++) begin
      hist[f][n] = cur(f);
      st[f] = settled(f, n - 1);
      sy[f] = h(f, n - DEPTH);
      all_st &= st[f];
      all_eq &= (sy[f] == m_held[f]);
    end
    m_ready = !m_locked && all_st && all_eq;
    if (st[0]) m_held[0] = sy[0];
    if (!m_locked) begin
      for (int f = 1; f < 6; f++) if (st[f]) m_held[f] = sy[f];
      if (st[0] && sy[0] == 1) m_locked = 1;
    end else if (st[0] && sy[0] == 0) begin
      m_locked = 0;
      m_viol = 0;
    end else begin
      for (int f = 1; f < 6; f++) if (st[f] && sy[f] != m_held[f]) m_viol = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("spi_en_stable", 32'(spi_en_stable), m_held[0]);
    chk("thresh_stable", 32'(thr_stable), m_held[1]);
    chk("window_stable", win_stable, m_held[2]);
    chk("integ_en_stable", 32'(integ_en_stable), m_held[3]);
    chk("skip_stable", 32'(skip_stable), m_held[4]);
    chk("debug_stable", 32'(debug_stable), m_held[5]);
    chk("cfg_locked", 32'(cfg_locked), 32'(m_locked));
    chk("cfg_lock_viol", 32'(cfg_lock_viol), 32'(m_viol));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
  endtask

  task automatic step(input int cycles = 1);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      model_edge();
      #1 check_all();
    end
  endtask

  task automatic set_field(input int f, input logic [31:0] v);
    case (f)
      0: spi_en = v[0];
      1: thr = v[14:0];
      2: win = v;
      3: integ_en = v[0];
      4: skip = v[15:0];
      default: debug = v[0];
    endcase
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_en"}, 32'(spi_en_stable), 0);
    chk({tag, "_thr"}, 32'(thr_stable), 0);
    chk({tag, "_win"}, win_stable, 0);
    chk({tag, "_ien"}, 32'(integ_en_stable), 0);
    chk({tag, "_skip"}, 32'(skip_stable), 0);
    chk({tag, "_dbg"}, 32'(debug_stable), 0);
    chk({tag, "_locked"}, 32'(cfg_locked), 0);
    chk({tag, "_viol"}, 32'(cfg_lock_viol), 0);
    chk({tag, "_ready"}, 32'(cfg_ready), 0);
  endtask

  initial begin
    resetn = 0; spi_en = 0; integ_en = 0; debug = 0; thr = '0; win = '0; skip = '0;
    model_reset();
    #12 check_zero("reset");
    win = 32'h0000_1000;
    @(negedge clk) resetn = 1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("win_before_settle", win_stable, 32'h0);
    end
    step();
    chk("win_at_edge6", win_stable, 32'h1000);
    step();
    chk("ready_after_win", 32'(cfg_ready), 1);
    // Fast toggling must never reach the held output.
    for (int e = 0; e < 20; e++) begin
      debug = ~debug;
      step();
      chk("debug_toggle", 32'(debug_stable), 0);
    end
    debug = 1;
    step(5);
    chk("debug_edge5", 32'(debug_stable), 0);
    step();
    chk("debug_edge6", 32'(debug_stable), 1);
    step(2);
    thr = 15'h0100;
    step();
    spi_en = 1;
    step(8);
    chk("locked", 32'(cfg_locked), 1);
    chk("ready_locked", 32'(cfg_ready), 0);
    thr = 15'h0200;
    step(8);
    chk("thr_frozen", 32'(thr_stable), 32'h0100);
    chk("viol_set", 32'(cfg_lock_viol), 1);
    spi_en = 0;
    step(8);
    chk("unlocked", 32'(cfg_locked), 0);
    chk("viol_clear", 32'(cfg_lock_viol), 0);
    chk("thr_after_unlock", 32'(thr_stable), 32'h0200);
    skip = 16'hFFFF;
    spi_en = 1;
    step(8);
    chk("locked_skip", 32'(cfg_locked), 1);
    #2 resetn = 0;
    model_reset();
    #1 check_zero("midrun_reset");
    @(negedge clk) resetn = 1;
    step(10);
    chk("relocked", 32'(cfg_locked), 1);
    chk("skip_reconverged", 32'(skip_stable), 32'hFFFF);
    spi_en = 0;
    step(8);
    skip = 16'h1234;
    spi_en = 1;
    step(8);
    chk("skip_with_lock", 32'(skip_stable), 32'h1234);
    chk("no_viol_on_lock", 32'(cfg_lock_viol), 0);
    chk("locked_again", 32'(cfg_locked), 1);
    for (int i = 0; i < 500; i++) begin
      int r = $urandom_range(0, 11);
      if (r < 4) begin
        int f = $urandom_range(1, 5);
        set_field(f, $urandom() & MASK[f]);
      end else if (r == 4 && $urandom_range(0, 2) == 0) begin
        spi_en = ~spi_en;
      end
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
